// File: rtl/capture_timer_pkg.sv
// Shared types and constants for the capture_timer block (state encoding, default sizes).
package capture_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_CNT_W      = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    // Ceiling log2, usable in parameter expressions; bounded at 2^30.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/capture_timer_if.sv
// Valid/ready timestamp stream from capture_timer to the readout logic.
interface capture_timer_if
    import capture_timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic [CNT_W-1:0] cap_data_o;
    logic             cap_valid_o;
    logic             cap_ready_i;

    modport master (output cap_data_o, output cap_valid_o, input cap_ready_i);
    modport slave  (input cap_data_o, input cap_valid_o, output cap_ready_i);
endinterface

// File: rtl/capture_fifo.sv
// Small synchronous first-word-fall-through FIFO holding captured timestamps.
module capture_fifo
    import capture_timer_pkg::*;
#(
    parameter int WIDTH = DEF_CNT_W,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int LVL_W = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             full,
    output logic [LVL_W-1:0] level
);
    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign valid   = (level != '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign pop_ok  = pop & valid;
    assign push_ok = push & (~full | pop_ok);
    // Head is forced to zero while empty so stale entries never leak out.
    assign data    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/capture_timer.sv
// Armed free-running counter whose value is pushed into a FIFO on each capture pulse.
// Define CAPTURE_TIMER_DELTA_EN to push differences between successive captures instead.
module capture_timer
    import capture_timer_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LVL_W      = clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_pulse_i,
    input  logic             capture_pulse_i,
    input  logic             clear_pulse_i,
    capture_timer_if.master  cap,
    output logic [LVL_W-1:0] fifo_level_o,
    output logic             running_o,
    output logic             overrun_o,
    output logic             cnt_wrap_o
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] push_value;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             fifo_full;

    // A capture only counts in RUN and loses to a same-cycle start or clear.
    assign push_req  = (state == ST_RUN) & capture_pulse_i & ~start_pulse_i & ~clear_pulse_i;
    assign pop       = cap.cap_valid_o & cap.cap_ready_i;
    assign push_ok   = push_req & (~fifo_full | pop);
    assign running_o = (state == ST_RUN);

`ifdef CAPTURE_TIMER_DELTA_EN
    logic [CNT_W-1:0] last_cnt;
    logic             have_last;

    assign push_value = have_last ? (cnt - last_cnt) : cnt;

    // Only accepted pushes advance the reference; a restart forces an absolute value next.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_pulse_i || start_pulse_i) begin
            last_cnt  <= '0;
            have_last <= 1'b0;
        end else if (push_ok) begin
            last_cnt  <= cnt;
            have_last <= 1'b1;
        end
    end
`else
    assign push_value = cnt;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_pulse_i) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            overrun_o  <= 1'b0;
            cnt_wrap_o <= 1'b0;
        end else if (start_pulse_i) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
                cnt_wrap_o <= 1'b1;
            end
            if (push_req && fifo_full && !pop) begin
                overrun_o <= 1'b1;
            end
        end
    end

    capture_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push_ok),
        .pop       (pop),
        .flush     (clear_pulse_i),
        .push_data (push_value),
        .data      (cap.cap_data_o),
        .valid     (cap.cap_valid_o),
        .full      (fifo_full),
        .level     (fifo_level_o)
    );

endmodule

// File: tb/tb_capture_timer.sv
// Bench for capture_timer: a 32-bit and a 4-bit instance share stimulus and one reference model.
module tb_capture_timer;
    import capture_timer_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, capture, clear, ready;

    capture_timer_if #(.CNT_W(32)) bus32 ();
    capture_timer_if #(.CNT_W(4))  bus4 ();
    assign bus32.cap_ready_i = ready;
    assign bus4.cap_ready_i  = ready;

    logic [2:0] lvl32, lvl4;
    logic run32, run4, ovr32, ovr4, wrap32, wrap4;

    capture_timer #(.CNT_W(32), .FIFO_DEPTH(DEPTH), .LVL_W(3)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_pulse_i(start), .capture_pulse_i(capture),
        .clear_pulse_i(clear), .cap(bus32.master), .fifo_level_o(lvl32),
        .running_o(run32), .overrun_o(ovr32), .cnt_wrap_o(wrap32)
    );

    capture_timer #(.CNT_W(4), .FIFO_DEPTH(DEPTH), .LVL_W(3)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_pulse_i(start), .capture_pulse_i(capture),
        .clear_pulse_i(clear), .cap(bus4.master), .fifo_level_o(lvl4),
        .running_o(run4), .overrun_o(ovr4), .cnt_wrap_o(wrap4)
    );

    // Reference state: timestamps are kept as raw elapsed-cycle counts and masked per width.
    longint cyc = 0;
    longint mStart = 0;
    bit     mRun = 0;
    bit     mOvr = 0;
    bit     mWrap32 = 0;
    bit     mWrap4 = 0;
    bit     mHave = 0;
    longint mLast = 0;
    longint q[$];

    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelEdge(input bit r, input bit s, input bit c, input bit cl, input bit rd);
        longint k;
        longint val;
        bit     doPop;
        bit     doPush;
        if (r || cl) begin
            mRun = 0; mOvr = 0; mWrap32 = 0; mWrap4 = 0; mHave = 0;
            q.delete();
        end else begin
            doPop  = (q.size() != 0) && rd;
            doPush = 0;
            val    = 0;
            k      = cyc - mStart - 1;
            if (s) begin
                mRun = 1; mStart = cyc; mHave = 0;
            end else if (mRun) begin
                if ((k % 16) == 15) mWrap4 = 1;
                if ((k % 64'h1_0000_0000) == 64'hFFFF_FFFF) mWrap32 = 1;
                if (c) begin
                    if (q.size() < DEPTH || doPop) begin
                        doPush = 1;
`ifdef CAPTURE_TIMER_DELTA_EN
                        val = mHave ? (k - mLast) : k;
                        mLast = k;
                        mHave = 1;
`else
                        val = k;
`endif
                    end else begin
                        mOvr = 1;
                    end
                end
            end
            if (doPop) void'(q.pop_front());
            if (doPush) q.push_back(val);
        end
        cyc++;
    endtask

    task automatic checkAll();
        logic [63:0] head;
        head = (q.size() != 0) ? q[0] : 64'd0;
        checkOutput("data32",  64'(bus32.cap_data_o),  head & 64'hFFFF_FFFF);
        checkOutput("data4",   64'(bus4.cap_data_o),   head & 64'hF);
        checkOutput("valid32", 64'(bus32.cap_valid_o), 64'(q.size() != 0));
        checkOutput("valid4",  64'(bus4.cap_valid_o),  64'(q.size() != 0));
        checkOutput("level32", 64'(lvl32), 64'(q.size()));
        checkOutput("level4",  64'(lvl4),  64'(q.size()));
        checkOutput("run32",   64'(run32), 64'(mRun));
        checkOutput("run4",    64'(run4),  64'(mRun));
        checkOutput("ovr32",   64'(ovr32), 64'(mOvr));
        checkOutput("ovr4",    64'(ovr4),  64'(mOvr));
        checkOutput("wrap32",  64'(wrap32), 64'(mWrap32));
        checkOutput("wrap4",   64'(wrap4),  64'(mWrap4));
    endtask

    // Drive one cycle of inputs away from the edge, advance the model, then sample just after the edge.
    task automatic applyStimulus(input bit r, input bit s, input bit c, input bit cl, input bit rd);
        @(negedge clk);
        rst = r; start = s; capture = c; clear = cl; ready = rd;
        modelEdge(r, s, c, cl, rd);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    initial begin
        logic [63:0] deltaExp [4];
        int readyMode;
        rst = 1'b1; start = 1'b0; capture = 1'b0; clear = 1'b0; ready = 1'b0;

        $display("[TB] reset and basic capture");
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_valid", 64'(bus32.cap_valid_o), 64'd0);
        checkOutput("rst_data",  64'(bus32.cap_data_o),  64'd0);
        checkOutput("rst_level", 64'(lvl32), 64'd0);
        checkOutput("rst_run",   64'(run32), 64'd0);
        applyStimulus(0, 1, 0, 0, 1);
        for (int i = 1; i <= 26; i++) begin
            applyStimulus(0, 0, (i == 10 || i == 25), 0, 1);
            if (i == 10) checkOutput("tp1_first",  64'(bus32.cap_data_o), 64'd9);
            if (i == 25) checkOutput("tp1_second", 64'(bus32.cap_data_o), 64'd24);
        end
        checkOutput("tp1_drained", 64'(lvl32), 64'd0);

        $display("[TB] overrun with stalled consumer");
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 1; i <= 7; i++) applyStimulus(0, 0, (i >= 3), 0, 0);
        checkOutput("tp2_level", 64'(lvl32), 64'd4);
        checkOutput("tp2_ovr",   64'(ovr32), 64'd1);
        for (int j = 0; j < 4; j++) begin
            checkOutput("tp2_read", 64'(bus32.cap_data_o), 64'(2 + j));
            applyStimulus(0, 0, 0, 0, 1);
        end

        $display("[TB] ignored captures");
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("idle_cap_valid", 64'(bus32.cap_valid_o), 64'd0);
        checkOutput("idle_cap_ovr",   64'(ovr32), 64'd0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("start_cap_valid", 64'(bus32.cap_valid_o), 64'd0);
        checkOutput("start_cap_ovr",   64'(ovr32), 64'd0);

        $display("[TB] narrow counter wrap and clear");
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) applyStimulus(0, 0, (i == 20), 0, 0);
        checkOutput("tp4_data4", 64'(bus4.cap_data_o), 64'd3);
        checkOutput("tp4_wrap4", 64'(wrap4), 64'd1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("tp4_clr_run",   64'(run4), 64'd0);
        checkOutput("tp4_clr_valid", 64'(bus4.cap_valid_o), 64'd0);
        checkOutput("tp4_clr_wrap",  64'(wrap4), 64'd0);

        $display("[TB] full FIFO with simultaneous pop");
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("tp5_level", 64'(lvl32), 64'd4);
        checkOutput("tp5_ovr",   64'(ovr32), 64'd0);
        checkOutput("tp5_head",  64'(bus32.cap_data_o), 64'd1);

        $display("[TB] capture sequence with restart");
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 1; i <= 30; i++) applyStimulus(0, 0, (i == 10 || i == 15 || i == 30), 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(0, 0, (i == 4), 0, 0);
`ifdef CAPTURE_TIMER_DELTA_EN
        deltaExp[0] = 9; deltaExp[1] = 5; deltaExp[2] = 15; deltaExp[3] = 3;
`else
        deltaExp[0] = 9; deltaExp[1] = 14; deltaExp[2] = 29; deltaExp[3] = 3;
`endif
        for (int j = 0; j < 4; j++) begin
            checkOutput("tp6_read", 64'(bus32.cap_data_o), deltaExp[j]);
            applyStimulus(0, 0, 0, 0, 1);
        end

        $display("[TB] randomized traffic");
        readyMode = 0;
        for (int i = 0; i < 2000; i++) begin
            if ((i % 64) == 0) readyMode = int'($urandom_range(0, 1));
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 79) == 0,
                          (readyMode == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
